seg_scan: RTL

- Multiplexed 4-digit 7-segment display driver. Sits directly downstream of the binary-to-BCD converter.
- Consumes four BCD digits (thousands..units) and time-multiplexes them onto a common-anode display, one digit at a time.
- Digits are snapshotted once per full scan frame to prevent tearing.
- Supports leading-zero blanking, per-digit blink, decimal-point select and global enable.

---
 rtl/seg_scan_pkg.sv | 22 ++
 rtl/seg_decode.sv | 26 ++
 rtl/seg_scan.sv | 69 ++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared segment patterns and anode helpers for the 7-segment scanner
package seg_scan_pkg;
  // Patterns are {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low one-hot anode select for bit position pos (3 = leftmost).
  function automatic logic [3:0] an_sel(input logic [1:0] pos);
    return ~(4'b0001 << pos);
  endfunction
endpackage

// File: rtl/seg_decode.sv
// seg_decode: BCD digit to active-low 7-segment pattern, dash for 10-15
//   digit in  [3:0]  BCD digit
//   seg   out [6:0]  {g,f,e,d,c,b,a}, active low
module seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg_scan.sv
// seg_scan: 4-digit multiplexed common-anode 7-segment driver with frame snapshot, blanking and blink
//   clk, rst              clock, async active-high reset
//   en                    display enable (0 blanks all slots)
//   dec1..dec4            BCD digits, dec1 leftmost
//   blank_lz              suppress leading zeros (units always shown)
//   blink_mask, dp_sel    per-digit blink / decimal point, bit3 = dec1
//   an, seg, dp           registered active-low display drive, an[3] leftmost
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dec1,
  input  logic [3:0] dec2,
  input  logic [3:0] dec3,
  input  logic [3:0] dec4,
  input  logic       blank_lz,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [DW-1:0] div;
  logic [BW-1:0] bcnt;
  logic [1:0] idx, pos;
  logic [3:0][3:0] snap;
  logic [3:0] digit, zero;
  logic [6:0] pat;
  logic tick, bwrap, boff, blank;
  assign tick  = div == DW'(SCAN_DIV - 1);
  assign bwrap = bcnt == BW'(BLINK_DIV - 1);
  // Slot idx drives bit position 3-idx of an, snap, blink_mask and dp_sel.
  assign pos   = ~idx;
  assign digit = snap[pos];
  // zero[p]: every snapshot digit from the leftmost down to position p is zero; units never qualify.
  assign zero  = {snap[3] == 4'd0, snap[3:2] == 8'd0, snap[3:1] == 12'd0, 1'b0};
  assign blank = !en || (blank_lz && zero[pos]) || (boff && blink_mask[pos]);
  seg_decode u_decode (.digit(digit), .seg(pat));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      idx  <= '0;
      bcnt <= '0;
      boff <= 1'b0;
      snap <= '0;
      an   <= AN_OFF;
      seg  <= SEG_BLANK;
      dp   <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        idx  <= idx + 1'b1;
        bcnt <= bwrap ? '0 : bcnt + 1'b1;
        boff <= boff ^ bwrap;
        if (idx == 2'd3) snap <= {dec1, dec2, dec3, dec4};
        an   <= blank ? AN_OFF : an_sel(pos);
        seg  <= blank ? SEG_BLANK : pat;
        dp   <= blank || !dp_sel[pos];
      end
    end
  end
endmodule
